// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional statistics outputs are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          fifo_wr_en_o,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_almostfull_i,
    input  logic                          fifo_wr_ack_i,
    input  logic                          fifo_overflow_i,
`ifdef FIFO_ARB_STATS_EN
    output logic [15:0]                   wr_count_o,
    output logic [15:0]                   stall_count_o,
`endif
    output logic                          ack_err_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic                    wr_en_q, wr_en_d;
    logic [FIFO_WIDTH-1:0]   data_q, data_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic                    ack_pend_q;
    logic                    ack_err_q, ack_err_d;

    logic [NUM_REQ-1:0]      elig;
    logic                    space_ok;
    logic                    win_found;
    logic [PW-1:0]           win_idx;
    logic [PW-1:0]           cand;

    // A producer granted last edge is still updating its request, so mask it.
    assign elig = req_i & ~grant_q;

    // WRITE means a write is in flight and will take the last slot if almost full.
    assign space_ok = !fifo_full_i &&
                      !((state_q == WRITE) && fifo_almostfull_i);

    // Search eligible producers starting at the priority pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PW'((32'(ptr_q) + 32'(k)) % 32'(NUM_REQ));
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and next-output decision for the arbitration FSM.
    always_comb begin
        state_d = IDLE;
        grant_d = '0;
        wr_en_d = 1'b0;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (win_found && space_ok) begin
            state_d          = WRITE;
            wr_en_d          = 1'b1;
            grant_d[win_idx] = 1'b1;
            data_d  = req_data_i[32'(win_idx)*FIFO_WIDTH +: FIFO_WIDTH];
            ptr_d   = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
        end else if (win_found) begin
            state_d = BACKOFF;
        end
    end

    // A pending write must see exactly one ack; any overflow is an error.
    assign ack_err_d = ack_err_q | (ack_pend_q ^ fifo_wr_ack_i) |
                       fifo_overflow_i;

    // Arbitration FSM with registered FIFO-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            ptr_q      <= '0;
            ack_pend_q <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            ptr_q      <= ptr_d;
            ack_pend_q <= (state_q == WRITE);
            ack_err_q  <= ack_err_d;
        end
    end

    assign grant_o        = grant_q;
    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_data_in_o = data_q;
    assign ack_err_o      = ack_err_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] wr_count_q;
    logic [15:0] stall_count_q;

    // Count acknowledged writes and cycles stalled on FIFO space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            if (fifo_wr_ack_i)
                wr_count_q <= wr_count_q + 16'd1;
            if (state_q == BACKOFF)
                stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign wr_count_o    = wr_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized self-checking bench with a depth-8 FIFO
// model and a behavioural arbitration reference model.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   grant;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           fifo_almostfull;
    logic           fifo_wr_ack;
    logic           fifo_overflow;
    logic           ack_err;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]    wr_count;
    logic [15:0]    stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req),
        .req_data_i       (req_data),
        .grant_o          (grant),
        .fifo_wr_en_o     (fifo_wr_en),
        .fifo_data_in_o   (fifo_data_in),
        .fifo_full_i      (fifo_full),
        .fifo_almostfull_i(fifo_almostfull),
        .fifo_wr_ack_i    (fifo_wr_ack),
        .fifo_overflow_i  (fifo_overflow),
`ifdef FIFO_ARB_STATS_EN
        .wr_count_o       (wr_count),
        .stall_count_o    (stall_count),
`endif
        .ack_err_o        (ack_err)
    );

    // FIFO model: depth 8, registered ack/overflow, optional read and ack kill.
    int   cnt = 0;
    logic fifo_clr = 1'b1;
    logic rd = 1'b0;
    logic kill_ack = 1'b0;
    logic ack_r = 1'b0;
    logic ovf_r = 1'b0;

    assign fifo_full       = (cnt == DEPTH);
    assign fifo_almostfull = (cnt == DEPTH - 1);
    assign fifo_wr_ack     = ack_r;
    assign fifo_overflow   = ovf_r;

    always @(posedge clk) begin
        if (fifo_clr) begin
            cnt   <= 0;
            ack_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            ack_r <= fifo_wr_en && (cnt != DEPTH) && !kill_ack;
            ovf_r <= fifo_wr_en && (cnt == DEPTH);
            cnt   <= cnt + ((fifo_wr_en && cnt != DEPTH) ? 1 : 0)
                         - ((rd && cnt != 0) ? 1 : 0);
        end
    end

    // Reference model state.
    logic [N-1:0] m_grant;
    logic         m_wen;
    logic [W-1:0] m_data;
    logic         m_err;
    bit           m_pend;
    int           m_ptr;
    int           pmode;

    task automatic model_clear();
        m_grant = '0;
        m_wen   = 1'b0;
        m_data  = '0;
        m_err   = 1'b0;
        m_pend  = 1'b0;
        m_ptr   = 0;
    endtask

    // Predict the next edge from current inputs, clock it, let producers react.
    task automatic tick();
        logic [N-1:0] elig;
        bit space;
        int w;
        if ((m_pend != fifo_wr_ack) || fifo_overflow) m_err = 1'b1;
        m_pend = m_wen;
        elig  = req & ~m_grant;
        space = !fifo_full && !(m_wen && fifo_almostfull);
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_grant = '0;
        if (w >= 0 && space) begin
            m_wen      = 1'b1;
            m_grant[w] = 1'b1;
            m_data     = req_data[w*W +: W];
            m_ptr      = (w + 1) % N;
        end else begin
            m_wen = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_grant[i]) begin
                req_data[i*W +: W] = W'($urandom);
                if (pmode != 0) req[i] = 1'($urandom);
            end else if (pmode != 0 && !req[i]) begin
                req[i] = 1'($urandom);
                req_data[i*W +: W] = W'($urandom);
            end
        end
    endtask

    task automatic reset_assert();
        @(negedge clk);
        rst_n    = 1'b0;
        fifo_clr = 1'b1;
        kill_ack = 1'b0;
        rd       = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_release();
        rst_n    = 1'b1;
        fifo_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] word;
        pmode = 0;
        req = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        reset_assert();
        checks++;
        if ({grant, fifo_wr_en, fifo_data_in, ack_err} !== '0) begin
            errors++;
            $display("FAIL reset_outs grant=%b wen=%b data=%h err=%b want 0",
                     grant, fifo_wr_en, fifo_data_in, ack_err);
        end
        reset_release();
        for (int k = 0; k < 5; k++) begin
            word = req_data[(k % N)*W +: W];
            tick();
            checks++;
            if (grant !== (4'b0001 << (k % N)) || fifo_wr_en !== 1'b1) begin
                errors++;
                $display("FAIL rr_order[%0d] grant=%b wen=%b want %b", k,
                         grant, fifo_wr_en, 4'b0001 << (k % N));
            end
            checks++;
            if (fifo_data_in !== word) begin
                errors++;
                $display("FAIL rr_data[%0d] got %h want %h", k,
                         fifo_data_in, word);
            end
        end
    endtask

    task automatic test_single_producer();
        logic prev_wen;
        reset_assert();
        pmode = 0;
        req = 4'b0100;
        reset_release();
        prev_wen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (grant !== ((k % 2 == 0) ? 4'b0100 : 4'b0000) ||
                grant !== m_grant) begin
                errors++;
                $display("FAIL single_grant[%0d] got %b model %b", k,
                         grant, m_grant);
            end
            checks++;
            if (prev_wen && fifo_wr_en) begin
                errors++;
                $display("FAIL single_b2b[%0d] wen got 1 want 0", k);
            end
            prev_wen = fifo_wr_en;
        end
    endtask

    task automatic test_fill_and_read();
        int writes = 0;
        reset_assert();
        pmode = 0;
        req = 4'b1111;
        reset_release();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fifo_wr_en === 1'b1) writes++;
            checks++;
            if ({grant, fifo_wr_en, fifo_data_in} !== {m_grant, m_wen, m_data}) begin
                errors++;
                $display("FAIL fill_cycle[%0d] grant=%b wen=%b data=%h want %b %b %h",
                         k, grant, fifo_wr_en, fifo_data_in, m_grant, m_wen, m_data);
            end
        end
        checks++;
        if (writes !== DEPTH || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_count got %0d full=%b want %0d full=1",
                     writes, fifo_full, DEPTH);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        checks++;
        if (fifo_wr_en !== 1'b1 || grant !== 4'b0001) begin
            errors++;
            $display("FAIL resume wen=%b grant=%b want 1 0001",
                     fifo_wr_en, grant);
        end
        writes = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (fifo_wr_en === 1'b1) writes++;
        end
        checks++;
        if (writes !== 1 || ack_err !== 1'b0 || fifo_overflow !== 1'b0) begin
            errors++;
            $display("FAIL one_more writes=%0d err=%b ovf=%b want 1 0 0",
                     writes, ack_err, fifo_overflow);
        end
    endtask

    task automatic test_ack_fault();
        reset_assert();
        pmode = 0;
        req = 4'b0001;
        reset_release();
        kill_ack = 1'b1;
        tick();
        tick();
        kill_ack = 1'b0;
        tick();
        checks++;
        if (ack_err !== 1'b1 || m_err !== 1'b1) begin
            errors++;
            $display("FAIL ack_err_set got %b model %b want 1", ack_err, m_err);
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (ack_err !== 1'b1) begin
            errors++;
            $display("FAIL ack_err_sticky got %b want 1", ack_err);
        end
    endtask

    task automatic test_reset_midop();
        reset_assert();
        pmode = 0;
        req = 4'b1111;
        reset_release();
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, fifo_wr_en, fifo_data_in, ack_err} !== '0) begin
            errors++;
            $display("FAIL async_reset grant=%b wen=%b data=%h err=%b want 0",
                     grant, fifo_wr_en, fifo_data_in, ack_err);
        end
        reset_assert();
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (wr_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset wr=%0d stall=%0d want 0 0",
                     wr_count, stall_count);
        end
`endif
        reset_release();
        tick();
        checks++;
        if (grant !== 4'b0001 || fifo_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL restart grant=%b wen=%b want 0001 1",
                     grant, fifo_wr_en);
        end
    endtask

    task automatic test_random();
        reset_assert();
        pmode = 1;
        req = N'($urandom);
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
        reset_release();
        for (int k = 0; k < 400; k++) begin
            rd = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if ({grant, fifo_wr_en, fifo_data_in, ack_err} !==
                {m_grant, m_wen, m_data, m_err}) begin
                errors++;
                $display("FAIL rand[%0d] grant=%b wen=%b data=%h err=%b want %b %b %h %b",
                         k, grant, fifo_wr_en, fifo_data_in, ack_err,
                         m_grant, m_wen, m_data, m_err);
            end
            checks++;
            if (fifo_overflow !== 1'b0) begin
                errors++;
                $display("FAIL rand_ovf[%0d] got %b want 0", k, fifo_overflow);
            end
        end
        checks++;
        if (ack_err !== 1'b0) begin
            errors++;
            $display("FAIL rand_err got %b want 0", ack_err);
        end
    endtask

    initial begin
        model_clear();
        pmode = 0;
        test_reset();
        test_single_producer();
        test_fill_and_read();
        test_ack_fault();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that lets NUM_REQ independent producers share the single write port of the team's synchronous FIFO. Each cycle it picks at most one requesting producer, registers that producer's word onto the FIFO's wr_en/data_in, and returns a one-cycle grant. It throttles on full/almostfull so the FIFO never overflows. It checks every issued write against the FIFO's wr_ack/overflow response and flags protocol errors.

## Interface
- NUM_REQ, 4: number of producers, 2..8
- FIFO_WIDTH, 16: data word width; must match the FIFO
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-producer write request; held until granted
- req_data  in  NUM_REQ*FIFO_WIDTH  producer i's word at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- grant  out  NUM_REQ  one-hot, one-cycle pulse: producer's word is being written this cycle
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_data_in  out  FIFO_WIDTH  to FIFO data_in
- fifo_full  in  1  from FIFO full
- fifo_almostfull  in  1  from FIFO almostfull (exactly one free slot)
- fifo_wr_ack  in  1  from FIFO wr_ack (registered, one cycle after wr_en)
- fifo_overflow  in  1  from FIFO overflow (registered, one cycle after wr_en)
- ack_err  out  1  sticky: an issued write was not acknowledged, or overflow was seen

## Operation
- All outputs are registered. Reset values: grant=0, fifo_wr_en=0, fifo_data_in=0, ack_err=0, priority pointer=0, state=IDLE.
- FSM states:
  - IDLE: no eligible request.
  - WRITE: a write was issued last edge.
  - BACKOFF: stalled on FIFO space.
- Eligible set = req & ~grant. A producer granted at edge t is masked at edge t+1, because it updates req/req_data in response to grant. A single producer therefore gets at most one write per two cycles.
- Space rule: a write may issue at an edge only if !fifo_full && !(fifo_wr_en && fifo_almostfull). The in-flight write consumes the last slot.
- Each edge:
  - If the eligible set is non-empty and the space rule holds: winner = first eligible index at or after pointer (wrapping). Set fifo_wr_en=1, fifo_data_in=req_data[winner], grant[winner]=1, pointer=(winner+1) mod NUM_REQ. Go to WRITE.
  - Else if the eligible set is non-empty (space rule fails): fifo_wr_en=0, grant=0, pointer unchanged. Go to BACKOFF.
  - Else: fifo_wr_en=0, grant=0. Go to IDLE.
- fifo_data_in holds its last value while fifo_wr_en=0.
- Ack check, one cycle after fifo_wr_en=1: if fifo_wr_ack=0 or fifo_overflow=1, set ack_err. Also set ack_err if fifo_wr_ack=1 without a preceding wr_en. ack_err clears only on reset.
- Reset mid-operation: everything returns to reset values immediately. The in-flight write's ack is not checked.

## Timing
- Request to write latency: 1 edge. req sampled high at edge t gives fifo_wr_en and grant high in cycle t..t+1.
- Throughput: 1 write/cycle when at least 2 producers alternate and the FIFO has space.
- Full to resume: when fifo_full falls at edge t (after a FIFO read), a write may issue at edge t+1.
- Fairness: with all producers requesting continuously and no backpressure, each producer is granted once per NUM_REQ cycles. Grant order is 0,1,2,...,NUM_REQ-1,0,...

## Configuration
- FIFO_ARB_STATS_EN defined adds two outputs:
  - wr_count (16 bits): counts fifo_wr_ack pulses.
  - stall_count (16 bits): counts cycles spent in BACKOFF.
  - Both counters wrap modulo 2^16 and reset to 0.
- FIFO_ARB_STATS_EN not defined: neither port nor counter exists. Arbitration behaviour is identical either way.

## Test plan
- Reset with req=4'b1111: grant=0, fifo_wr_en=0, ack_err=0. After release, grants go 0,1,2,3,0 on consecutive cycles; fifo_data_in matches each producer's word.
- Single producer, req=4'b0100 held: grant[2] pulses every other cycle; fifo_wr_en never high on two consecutive cycles.
- FIFO depth 8, no reads, all producers requesting: exactly 8 writes issue, then the arbiter enters BACKOFF. fifo_overflow stays 0 and ack_err stays 0.
- One FIFO read while full: exactly one further write issues, starting with the producer after the last winner.
- Force fifo_wr_ack=0 one cycle after a write: ack_err=1 and stays 1 until rst_n falls.
- Assert rst_n=0 while fifo_wr_en=1: all outputs are 0 asynchronously. After release, arbitration restarts from producer 0. With FIFO_ARB_STATS_EN, both counters read 0.
